// File: rtl/pc_controller.sv
`default_nettype none
// ============================================================================
// Module   : pc_controller
// Purpose  : Sequences the CR16 program counter. Requests an instruction,
//            decodes Bcond / Jcond / JAL against the flags captured with it,
//            and presents select/address values to the PC. It then fires a
//            one-cycle enable strobe so the PC increments, displaces or loads.
// Ports    : I_CLK, I_RESET (async, active-high)
//            I_INSTRUCTION / I_INSTRUCTION_VALID : instruction from fetch
//            I_FLAGS {C,L,F,Z,N}, I_TARGET (Rtarget value), I_STALL
//            O_FETCH_REQUEST, O_PC_ENABLE, O_PC_ADDRESS, O_PC_ADDRESS_SELECT,
//            O_PC_ADDRESS_SELECT_INCREMENT (tied 0), O_PC_ADDRESS_SELECT_DISPLACE,
//            O_LINK_WRITE, O_LINK_REGISTER, O_BRANCH_TAKEN
// Revision : 1.0  initial release
// ============================================================================
module pc_controller #(
  parameter int P_ADDRESS_WIDTH     = 16,
  parameter int P_INSTRUCTION_WIDTH = 16
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic [P_INSTRUCTION_WIDTH-1:0] I_INSTRUCTION,
  input  logic                           I_INSTRUCTION_VALID,
  input  logic [4:0]                     I_FLAGS,
  input  logic [P_ADDRESS_WIDTH-1:0]     I_TARGET,
  input  logic                           I_STALL,
  output logic                           O_FETCH_REQUEST,
  output logic                           O_PC_ENABLE,
  output logic [P_ADDRESS_WIDTH-1:0]     O_PC_ADDRESS,
  output logic                           O_PC_ADDRESS_SELECT,
  output logic                           O_PC_ADDRESS_SELECT_INCREMENT,
  output logic                           O_PC_ADDRESS_SELECT_DISPLACE,
  output logic                           O_LINK_WRITE,
  output logic [3:0]                     O_LINK_REGISTER,
  output logic                           O_BRANCH_TAKEN
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_STROBE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [P_INSTRUCTION_WIDTH-1:0] r_instr;
  logic [4:0]                     r_flags;
  logic [P_ADDRESS_WIDTH-1:0]     r_target;
  logic                           r_select;
  logic                           r_displace;
  logic [P_ADDRESS_WIDTH-1:0]     r_address;
  logic                           r_link_write;
  logic [3:0]                     r_link_register;
  logic                           r_branch_taken;

  logic w_is_bcond;
  logic w_is_jcond;
  logic w_is_jal;
  logic w_cond_true;
  logic w_bcond_taken;
  logic w_jump_taken;
  logic w_unused_low;

  // Flag aliases, I_FLAGS = {C, L, F, Z, N}
  logic w_c, w_l, w_f, w_z, w_n;
  assign {w_c, w_l, w_f, w_z, w_n} = r_flags;

  // Rtarget index bits are resolved by the register file, not here
  assign w_unused_low = ^r_instr[3:0];

  assign w_is_bcond = (r_instr[15:12] == 4'b1100);
  assign w_is_jcond = (r_instr[15:12] == 4'b0100) && (r_instr[7:4] == 4'b1100);
  assign w_is_jal   = (r_instr[15:12] == 4'b0100) && (r_instr[7:4] == 4'b1000);

  always_comb begin
    w_cond_true = 1'b0;
    case (r_instr[11:8])
      4'b0000: w_cond_true = w_z;
      4'b0001: w_cond_true = !w_z;
      4'b0010: w_cond_true = w_c;
      4'b0011: w_cond_true = !w_c;
      4'b0100: w_cond_true = w_l;
      4'b0101: w_cond_true = !w_l;
      4'b0110: w_cond_true = w_n;
      4'b0111: w_cond_true = !w_n;
      4'b1000: w_cond_true = w_f;
      4'b1001: w_cond_true = !w_f;
      4'b1010: w_cond_true = !w_l && !w_z;
      4'b1011: w_cond_true = w_l || w_z;
      4'b1100: w_cond_true = !w_n && !w_z;
      4'b1101: w_cond_true = w_n || w_z;
      4'b1110: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_bcond_taken = w_is_bcond && w_cond_true;
  assign w_jump_taken  = (w_is_jcond && w_cond_true) || w_is_jal;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH:  if (I_INSTRUCTION_VALID) w_next_state = S_DECODE;
      S_DECODE: if (!I_STALL) w_next_state = S_STROBE;
      S_STROBE: w_next_state = S_FETCH;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state         <= S_IDLE;
      r_instr         <= '0;
      r_flags         <= '0;
      r_target        <= '0;
      r_select        <= 1'b0;
      r_displace      <= 1'b0;
      r_address       <= '0;
      r_link_write    <= 1'b0;
      r_link_register <= 4'd0;
      r_branch_taken  <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Flags and target are captured with the instruction only
      if (r_state == S_FETCH && I_INSTRUCTION_VALID) begin
        r_instr  <= I_INSTRUCTION;
        r_flags  <= I_FLAGS;
        r_target <= I_TARGET;
      end

      // Selects are registered on DECODE exit so they are settled for the
      // whole STROBE cycle in which the PC samples them
      if (r_state == S_DECODE && !I_STALL) begin
        r_select       <= w_bcond_taken || w_jump_taken;
        r_displace     <= w_bcond_taken;
        r_link_write   <= w_is_jal;
        r_branch_taken <= w_bcond_taken || w_jump_taken;
        if (w_is_jal) r_link_register <= r_instr[11:8];
        if (w_bcond_taken)
          r_address <= {{(P_ADDRESS_WIDTH-8){r_instr[7]}}, r_instr[7:0]};
        else if (w_jump_taken)
          r_address <= r_target;
        else
          r_address <= '0;
      end

      if (r_state == S_STROBE) begin
        r_select     <= 1'b0;
        r_displace   <= 1'b0;
        r_address    <= '0;
        r_link_write <= 1'b0;
      end
    end
  end

  assign O_FETCH_REQUEST               = (r_state == S_FETCH);
  assign O_PC_ENABLE                   = (r_state == S_STROBE);
  assign O_PC_ADDRESS                  = r_address;
  assign O_PC_ADDRESS_SELECT           = r_select;
  assign O_PC_ADDRESS_SELECT_INCREMENT = 1'b0;
  assign O_PC_ADDRESS_SELECT_DISPLACE  = r_displace;
  assign O_LINK_WRITE                  = r_link_write;
  assign O_LINK_REGISTER               = r_link_register;
  assign O_BRANCH_TAKEN                = r_branch_taken;

endmodule
`default_nettype wire
